// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one PSRAM controller between the picoBlaze port (0)
// and a streaming port (1); one single-word transaction in flight, watchdog-guarded.
module psram_arbiter #(
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 16,
  parameter int TIMEOUT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              ub0,
  input  logic              ub1,
  input  logic              lb0,
  input  logic              lb1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              grant0,
  output logic              grant1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  input  logic              ctrlr_good,
  input  logic              op_begun,
  input  logic              op_finished,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] mem_din,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_ub,
  output logic              mem_lb,
  output logic              mem_burst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t               state;
  logic                 last_grant;
  logic                 cur_port;
  logic                 cur_we;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 pick;
  logic                 timeout;

  assign mem_burst = 1'b0;

  // Sole requester wins; on a tie the port that was not served last wins.
  always_comb begin
    pick = ~last_grant;
    if (req0 && !req1)      pick = 1'b0;
    else if (req1 && !req0) pick = 1'b1;
  end

  assign timeout = ((state == S_ISSUE) || (state == S_WAIT)) && (wd_cnt == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      cur_port   <= 1'b0;
      cur_we     <= 1'b0;
      wd_cnt     <= '0;
      grant0     <= 1'b0;
      grant1     <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata      <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_ub     <= 1'b0;
      mem_lb     <= 1'b0;
      mem_addr   <= '0;
      mem_dout   <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      if (timeout) begin
        mem_rd     <= 1'b0;
        mem_wr     <= 1'b0;
        mem_ub     <= 1'b0;
        mem_lb     <= 1'b0;
        grant0     <= 1'b0;
        grant1     <= 1'b0;
        err0       <= ~cur_port;
        err1       <= cur_port;
        last_grant <= cur_port;
        state      <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (ctrlr_good && (req0 || req1)) begin
              cur_port <= pick;
              wd_cnt   <= '0;
              state    <= S_ISSUE;
              if (pick) begin
                cur_we   <= we1;
                mem_rd   <= ~we1;
                mem_wr   <= we1;
                mem_ub   <= ub1;
                mem_lb   <= lb1;
                mem_addr <= addr1;
                mem_dout <= wdata1;
                grant1   <= 1'b1;
              end else begin
                cur_we   <= we0;
                mem_rd   <= ~we0;
                mem_wr   <= we0;
                mem_ub   <= ub0;
                mem_lb   <= lb0;
                mem_addr <= addr0;
                mem_dout <= wdata0;
                grant0   <= 1'b1;
              end
            end
          end
          S_ISSUE: begin
            wd_cnt <= wd_cnt + 1'b1;
            if (op_begun) begin
              mem_rd <= 1'b0;
              mem_wr <= 1'b0;
              state  <= S_WAIT;
            end
          end
          S_WAIT: begin
            wd_cnt <= wd_cnt + 1'b1;
            if (data_ok && !cur_we) rdata <= mem_din;
            if (op_finished) begin
              done0      <= ~cur_port;
              done1      <= cur_port;
              last_grant <= cur_port;
              state      <= S_DONE;
            end
          end
          default: begin
            grant0 <= 1'b0;
            grant1 <= 1'b0;
            mem_ub <= 1'b0;
            mem_lb <= 1'b0;
            state  <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
